// File: rtl/control_unit_pkg.sv
// Shared encodings for the multicycle ARM-subset control unit: states, ALU ops,
// datapath mux codes, next-state types, and the per-state control word decode.
package control_unit_pkg;

  typedef enum logic [5:0] {
    ST_RESET  = 6'd0,
    ST_FETCH1 = 6'd1,
    ST_FETCH2 = 6'd2,
    ST_FETCH3 = 6'd3,
    ST_IRLOAD = 6'd4,
    ST_DECODE = 6'd5,
    ST_DP     = 6'd10,
    ST_ADDR   = 6'd20,
    ST_LOAD   = 6'd21,
    ST_LDWB   = 6'd22,
    ST_STDATA = 6'd24,
    ST_STORE  = 6'd25,
    ST_BL     = 6'd40,
    ST_B      = 6'd41
  } state_t;

  localparam logic [4:0] OP_ADD   = 5'b00100;
  localparam logic [4:0] OP_SUB   = 5'b00010;
  localparam logic [4:0] OP_PASSA = 5'b10000;
  localparam logic [4:0] OP_PASSB = 5'b01101;

  localparam logic [1:0] MA_RFA = 2'b00, MA_MDR = 2'b01, MA_ZERO = 2'b10;
  localparam logic [1:0] MB_SHF = 2'b00, MB_FOUR = 2'b01, MB_MDR = 2'b10, MB_SIMM = 2'b11;
  localparam logic [2:0] MC_RD = 3'b000, MC_RN = 3'b001, MC_R15 = 3'b011, MC_R14 = 3'b100;
  localparam logic       MD_MEM = 1'b0, MD_RFB = 1'b1;
  localparam logic       ME_ALU = 1'b0, ME_RFA = 1'b1;
  localparam logic [1:0] MF_RN = 2'b00, MF_RD = 2'b01, MF_PX = 2'b10;
  localparam logic       MG_RM = 1'b0, MG_RD = 1'b1;
  localparam logic       MH_UCODE = 1'b0, MH_IR = 1'b1;
  localparam logic [1:0] MI_ALU = 2'b00, MI_WORD = 2'b01, MI_BYTE = 2'b10;
  localparam logic [1:0] MJ_IMM8 = 2'b00, MJ_RMSH = 2'b01, MJ_IMM12 = 2'b10;

  localparam logic [2:0] T_FIXED = 3'b000, T_WAIT = 3'b001, T_DISPATCH = 3'b010, T_FETCH = 3'b011;

  typedef struct packed {
    logic       rfld;
    logic       irld;
    logic       marld;
    logic       mdrld;
    logic       frld;
    logic       rw;
    logic       mov;
    logic       typedata;
    logic [3:0] px;
    logic [1:0] ma;
    logic [1:0] mb;
    logic [2:0] mc;
    logic       md;
    logic       me;
    logic [1:0] mf;
    logic       mg;
    logic       mh;
    logic [1:0] mi;
    logic [1:0] mj;
    logic       e;
    logic [2:0] t;
    logic [4:0] op;
  } ctrl_t;

  // f = ir[25:20] = {I, P, U, B, W, L/S}
  function automatic ctrl_t decode_ctrl(state_t s, logic [5:0] f);
    ctrl_t c;
    c = '0;
    case (s)
      ST_FETCH1: begin
        c.mf = MF_PX; c.px = 4'hF; c.me = ME_RFA; c.marld = 1'b1;
      end
      ST_FETCH2: begin
        c.mf = MF_PX; c.px = 4'hF; c.ma = MA_RFA; c.mb = MB_FOUR; c.op = OP_ADD;
        c.mc = MC_R15; c.rfld = 1'b1; c.mov = 1'b1; c.rw = 1'b1;
      end
      ST_FETCH3: begin
        c.mov = 1'b1; c.rw = 1'b1; c.mdrld = 1'b1; c.md = MD_MEM; c.t = T_WAIT;
      end
      ST_IRLOAD: c.irld = 1'b1;
      ST_DECODE: c.t = T_DISPATCH;
      ST_DP: begin
        c.mh = MH_IR; c.mj = f[5] ? MJ_IMM8 : MJ_RMSH; c.e = 1'b1; c.frld = f[0];
        c.rfld = (f[4:3] != 2'b10);  // TST/TEQ/CMP/CMN only set flags
        c.mc = MC_RD; c.t = T_FETCH;
      end
      ST_ADDR: begin
        c.op = f[3] ? OP_ADD : OP_SUB; c.mj = f[5] ? MJ_RMSH : MJ_IMM12;
        c.mb = MB_SHF; c.mf = MF_RN; c.mc = MC_RN; c.marld = 1'b1; c.e = 1'b1;
        if (f[4]) begin
          c.me = ME_ALU; c.rfld = f[1];
        end else begin
          c.me = ME_RFA; c.rfld = 1'b1;
        end
      end
      ST_LOAD: begin
        c.mov = 1'b1; c.rw = 1'b1; c.typedata = f[2]; c.mdrld = 1'b1; c.md = MD_MEM;
        c.t = T_WAIT;
      end
      ST_LDWB: begin
        c.mc = MC_RD; c.mi = f[2] ? MI_BYTE : MI_WORD; c.rfld = 1'b1; c.t = T_FETCH;
      end
      ST_STDATA: begin
        c.mg = MG_RD; c.md = MD_RFB; c.mdrld = 1'b1;
      end
      ST_STORE: begin
        c.mov = 1'b1; c.rw = 1'b0; c.typedata = f[2]; c.t = T_WAIT;
      end
      ST_BL: begin
        c.mf = MF_PX; c.px = 4'hF; c.op = OP_PASSA; c.mc = MC_R14; c.rfld = 1'b1; c.e = 1'b1;
      end
      ST_B: begin
        c.mf = MF_PX; c.px = 4'hF; c.ma = MA_RFA; c.mb = MB_SIMM; c.op = OP_ADD;
        c.mc = MC_R15; c.rfld = 1'b1; c.e = 1'b1; c.t = T_FETCH;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/control_unit_next_state.sv
// Combinational next-state encoder: sequencing, memory waits and decode dispatch.
module control_unit_next_state
  import control_unit_pkg::*;
(
  input  state_t     state,
  input  logic [2:0] cls,
  input  logic       pbit,
  input  logic       lbit,
  input  logic       moc,
  output state_t     nxt
);

  always_comb begin
    nxt = ST_RESET;
    case (state)
      ST_RESET:  nxt = ST_FETCH1;
      ST_FETCH1: nxt = ST_FETCH2;
      ST_FETCH2: nxt = ST_FETCH3;
      ST_FETCH3: nxt = moc ? ST_IRLOAD : ST_FETCH3;
      ST_IRLOAD: nxt = ST_DECODE;
      ST_DECODE: begin
        if (cls[2:1] == 2'b00)      nxt = ST_DP;
        else if (cls[2:1] == 2'b01) nxt = ST_ADDR;
        else if (cls == 3'b101)     nxt = pbit ? ST_BL : ST_B;
        else                        nxt = ST_FETCH1;
      end
      ST_DP:     nxt = ST_FETCH1;
      ST_ADDR:   nxt = lbit ? ST_LOAD : ST_STDATA;
      ST_LOAD:   nxt = moc ? ST_LDWB : ST_LOAD;
      ST_LDWB:   nxt = ST_FETCH1;
      ST_STDATA: nxt = ST_STORE;
      ST_STORE:  nxt = moc ? ST_FETCH1 : ST_STORE;
      ST_BL:     nxt = ST_B;
      ST_B:      nxt = ST_FETCH1;
      default:   nxt = ST_RESET;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Moore control unit: state register plus a control word registered from the
// decode of the state being entered, so outputs always match S.
module control_unit
  import control_unit_pkg::*;
(
  input  logic        CLK,
  input  logic        CLR,
  input  logic        moc,
  input  logic [31:0] ir,
  output logic        RFLd,
  output logic        IRLd,
  output logic        MARLd,
  output logic        MDRLd,
  output logic        FRLd,
  output logic        RW,
  output logic        MOV,
  output logic        typeData,
  output logic [0:3]  px,
  output logic        MA1, MA0,
  output logic        MB1, MB0,
  output logic        MC2, MC1, MC0,
  output logic        MD,
  output logic        ME,
  output logic        MF1, MF0,
  output logic        MG,
  output logic        MH,
  output logic        MI1, MI0,
  output logic        MJ1, MJ0,
  output logic        E,
  output logic        T2, T1, T0,
  output logic        S5, S4, S3, S2, S1, S0,
  output logic        OP4, OP3, OP2, OP1, OP0
);

  state_t state, nxt;
  ctrl_t  ctrl;
  logic   unused_ir;

  assign unused_ir = ^{ir[31:28], ir[19:0]};

  control_unit_next_state u_next (
    .state (state),
    .cls   (ir[27:25]),
    .pbit  (ir[24]),
    .lbit  (ir[20]),
    .moc   (moc),
    .nxt   (nxt)
  );

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state <= ST_RESET;
      ctrl  <= '0;
    end else begin
      state <= nxt;
      ctrl  <= decode_ctrl(nxt, ir[25:20]);
    end
  end

  assign RFLd     = ctrl.rfld;
  assign IRLd     = ctrl.irld;
  assign MARLd    = ctrl.marld;
  assign MDRLd    = ctrl.mdrld;
  assign FRLd     = ctrl.frld;
  assign RW       = ctrl.rw;
  assign MOV      = ctrl.mov;
  assign typeData = ctrl.typedata;
  assign px       = ctrl.px;
  assign {MA1, MA0}      = ctrl.ma;
  assign {MB1, MB0}      = ctrl.mb;
  assign {MC2, MC1, MC0} = ctrl.mc;
  assign MD              = ctrl.md;
  assign ME              = ctrl.me;
  assign {MF1, MF0}      = ctrl.mf;
  assign MG              = ctrl.mg;
  assign MH              = ctrl.mh;
  assign {MI1, MI0}      = ctrl.mi;
  assign {MJ1, MJ0}      = ctrl.mj;
  assign E               = ctrl.e;
  assign {T2, T1, T0}    = ctrl.t;
  assign {S5, S4, S3, S2, S1, S0} = state;
  assign {OP4, OP3, OP2, OP1, OP0} = ctrl.op;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit with an expectation queue checked after each edge.
module tb_control_unit;

  logic        CLK, CLR, moc;
  logic [31:0] ir;
  logic        RFLd, IRLd, MARLd, MDRLd, FRLd, RW, MOV, typeData;
  logic [0:3]  px;
  logic        MA1, MA0, MB1, MB0, MC2, MC1, MC0, MD, ME, MF1, MF0, MG, MH;
  logic        MI1, MI0, MJ1, MJ0, E, T2, T1, T0;
  logic        S5, S4, S3, S2, S1, S0, OP4, OP3, OP2, OP1, OP0;

  control_unit dut (
    .CLK(CLK), .CLR(CLR), .moc(moc), .ir(ir),
    .RFLd(RFLd), .IRLd(IRLd), .MARLd(MARLd), .MDRLd(MDRLd), .FRLd(FRLd),
    .RW(RW), .MOV(MOV), .typeData(typeData), .px(px),
    .MA1(MA1), .MA0(MA0), .MB1(MB1), .MB0(MB0), .MC2(MC2), .MC1(MC1), .MC0(MC0),
    .MD(MD), .ME(ME), .MF1(MF1), .MF0(MF0), .MG(MG), .MH(MH),
    .MI1(MI1), .MI0(MI0), .MJ1(MJ1), .MJ0(MJ0), .E(E),
    .T2(T2), .T1(T1), .T0(T0),
    .S5(S5), .S4(S4), .S3(S3), .S2(S2), .S1(S1), .S0(S0),
    .OP4(OP4), .OP3(OP3), .OP2(OP2), .OP1(OP1), .OP0(OP0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  localparam int F_S = 0, F_T = 1, F_OP = 2, F_PX = 3, F_MB = 4, F_MC = 5, F_MD = 6;
  localparam int F_ME = 7, F_MH = 8, F_MI = 9, F_MJ = 10, F_E = 11, F_RFLD = 12;
  localparam int F_IRLD = 13, F_MARLD = 14, F_MDRLD = 15, F_FRLD = 16, F_RW = 17;
  localparam int F_MOV = 18, F_TYPE = 19, F_ALL = 20;

  typedef struct {
    string       tag;
    int          fld;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic logic [63:0] get_field(int fld);
    case (fld)
      F_S:     return 64'({S5, S4, S3, S2, S1, S0});
      F_T:     return 64'({T2, T1, T0});
      F_OP:    return 64'({OP4, OP3, OP2, OP1, OP0});
      F_PX:    return 64'(px);
      F_MB:    return 64'({MB1, MB0});
      F_MC:    return 64'({MC2, MC1, MC0});
      F_MD:    return 64'(MD);
      F_ME:    return 64'(ME);
      F_MH:    return 64'(MH);
      F_MI:    return 64'({MI1, MI0});
      F_MJ:    return 64'({MJ1, MJ0});
      F_E:     return 64'(E);
      F_RFLD:  return 64'(RFLd);
      F_IRLD:  return 64'(IRLd);
      F_MARLD: return 64'(MARLd);
      F_MDRLD: return 64'(MDRLd);
      F_FRLD:  return 64'(FRLd);
      F_RW:    return 64'(RW);
      F_MOV:   return 64'(MOV);
      F_TYPE:  return 64'(typeData);
      default: return 64'({RFLd, IRLd, MARLd, MDRLd, FRLd, RW, MOV, typeData, px,
                           MA1, MA0, MB1, MB0, MC2, MC1, MC0, MD, ME, MF1, MF0, MG, MH,
                           MI1, MI0, MJ1, MJ0, E, T2, T1, T0,
                           S5, S4, S3, S2, S1, S0, OP4, OP3, OP2, OP1, OP0});
    endcase
  endfunction

  task automatic chk(input string tag, input int fld, input logic [63:0] val);
    exp_t x;
    x.tag = tag; x.fld = fld; x.val = val;
    sb.push_back(x);
  endtask

  // Advance one edge, then retire every pending expectation against the DUT.
  task automatic step();
    exp_t x;
    logic [63:0] obs;
    @(posedge CLK);
    #1;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      obs = get_field(x.fld);
      vectors++;
      assert (obs === x.val) else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", x.tag, obs, x.val);
      end
    end
  endtask

  task automatic fetch(input logic [31:0] instr);
    ir = instr; moc = 1'b1;
    chk("f1_s", F_S, 1); chk("f1_marld", F_MARLD, 1); chk("f1_px", F_PX, 4'hF);
    chk("f1_me", F_ME, 1); step();
    chk("f2_s", F_S, 2); chk("f2_rfld", F_RFLD, 1); chk("f2_mc", F_MC, 3);
    chk("f2_op", F_OP, 5'b00100); chk("f2_mb", F_MB, 1); chk("f2_mov", F_MOV, 1); step();
    chk("f3_s", F_S, 3); chk("f3_mdrld", F_MDRLD, 1); chk("f3_t", F_T, 1); step();
    chk("f4_s", F_S, 4); chk("f4_irld", F_IRLD, 1); step();
    chk("f5_s", F_S, 5); chk("f5_t", F_T, 2); chk("f5_rfld", F_RFLD, 0); step();
  endtask

  initial begin
    CLR = 1'b1; moc = 1'b0; ir = 32'h0;
    step();
    step();
    chk("rst_s", F_S, 0); chk("rst_all", F_ALL, 0); step();
    CLR = 1'b0;

    // ADDS r2,r1,r3
    fetch(32'hE0912003);
    chk("adds_s", F_S, 10); chk("adds_rfld", F_RFLD, 1); chk("adds_frld", F_FRLD, 1);
    chk("adds_mh", F_MH, 1); chk("adds_e", F_E, 1); chk("adds_mj", F_MJ, 1);
    chk("adds_t", F_T, 3); step();

    // CMP with a slow instruction fetch
    ir = 32'hE1510002; moc = 1'b1;
    chk("w1_s", F_S, 1); step();
    chk("w2_s", F_S, 2); step();
    moc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wait_s", F_S, 3); chk("wait_mov", F_MOV, 1); chk("wait_rw", F_RW, 1); step();
    end
    moc = 1'b1;
    chk("w4_s", F_S, 4); chk("w4_irld", F_IRLD, 1); step();
    chk("w5_s", F_S, 5); step();
    chk("cmp_s", F_S, 10); chk("cmp_rfld", F_RFLD, 0); chk("cmp_frld", F_FRLD, 1); step();

    // LDRB r3,[r1,#2]
    fetch(32'hE5D13002);
    chk("ldrb20_s", F_S, 20); chk("ldrb20_marld", F_MARLD, 1); chk("ldrb20_op", F_OP, 5'b00100);
    chk("ldrb20_rfld", F_RFLD, 0); chk("ldrb20_mj", F_MJ, 2); chk("ldrb20_me", F_ME, 0); step();
    chk("ldrb21_s", F_S, 21); chk("ldrb21_mov", F_MOV, 1); chk("ldrb21_rw", F_RW, 1);
    chk("ldrb21_type", F_TYPE, 1); chk("ldrb21_mdrld", F_MDRLD, 1); step();
    chk("ldrb22_s", F_S, 22); chk("ldrb22_rfld", F_RFLD, 1); chk("ldrb22_mc", F_MC, 0);
    chk("ldrb22_mi", F_MI, 2); step();

    // BL +4
    fetch(32'hEB000004);
    chk("bl40_s", F_S, 40); chk("bl40_rfld", F_RFLD, 1); chk("bl40_mc", F_MC, 4);
    chk("bl40_op", F_OP, 5'b10000); step();
    chk("b41_s", F_S, 41); chk("b41_mb", F_MB, 3); chk("b41_mc", F_MC, 3);
    chk("b41_e", F_E, 1); step();

    // STR r3,[r1]
    fetch(32'hE5813000);
    chk("str20_s", F_S, 20); chk("str20_marld", F_MARLD, 1); step();
    chk("str24_s", F_S, 24); chk("str24_mdrld", F_MDRLD, 1); chk("str24_md", F_MD, 1); step();
    chk("str25_s", F_S, 25); chk("str25_mov", F_MOV, 1); chk("str25_rw", F_RW, 0);
    chk("str25_type", F_TYPE, 0); step();

    // LDR r3,[r1] interrupted by reset during the memory wait
    fetch(32'hE5913000);
    moc = 1'b0;
    chk("ldr20_s", F_S, 20); step();
    chk("ldr21_s", F_S, 21); chk("ldr21_type", F_TYPE, 0); step();
    CLR = 1'b1;
    chk("clr_s", F_S, 0); chk("clr_all", F_ALL, 0); step();
    CLR = 1'b0;
    chk("post_clr_s", F_S, 1); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
